// File: rtl/dsp_add_reg_if.sv
// dsp_add_reg_if
// Operand/result bundle between a producer and one dsp_add_reg instance.
// Ports (as seen from the master / producer side):
//   en        out  clock enable for every pipeline stage; low = full stall
//   valid_in  out  a/b carry a valid operand pair this cycle
//   a, b      out  two's complement addends, width bits
//   valid_out in   y holds a valid sum
//   y         in   registered (a + b) mod 2^width
interface dsp_add_reg_if #(
  parameter int width = 48
);
  logic             en;
  logic             valid_in;
  logic [width-1:0] a;
  logic [width-1:0] b;
  logic             valid_out;
  logic [width-1:0] y;

  modport master (
    output en,
    output valid_in,
    output a,
    output b,
    input  valid_out,
    input  y
  );

  modport slave (
    input  en,
    input  valid_in,
    input  a,
    input  b,
    output valid_out,
    output y
  );
endinterface

// File: rtl/dsp_add_reg.sv
// dsp_add_reg
// Pipelined two-operand adder built around one DSP48E2-style slice:
// y = (a + b) mod 2^width, two enabled cycles of latency, one pair per
// enabled cycle. The slice datapath is written out behaviourally with the
// same register placement as the hard primitive (A2/B2/C input registers,
// P output register) so it maps onto a single DSP slice.
// Ports:
//   clock  in   single clock for all state
//   reset  in   synchronous, active-high; clears every pipeline stage and
//               wins over bus.en
//   bus    slave modport of dsp_add_reg_if (en, valid_in, a, b in;
//               valid_out, y out)
module dsp_add_reg #(
  parameter int width = 48
) (
  input logic          clock,
  input logic          reset,
  dsp_add_reg_if.slave bus
);

  // Static slice configuration; the control inputs never change, so the
  // slice control registers are bypassed.
  localparam logic [3:0] ALUMODE    = 4'b0000;       // Z + W + X + Y + CIN
  localparam logic [8:0] OPMODE     = 9'b000110011;  // X=A:B, Y=0, Z=C, W=0
  localparam logic [2:0] CARRYINSEL = 3'b000;        // CIN from CARRYIN pin
  localparam logic       CARRYIN    = 1'b0;

  // Width legality is checked at elaboration.
  if (width < 1 || width > 48) begin : g_width_check
    $error("dsp_add_reg: width %0d outside legal range 1..48", width);
  end

  // ---------------------------------------------------------------------
  // Operand mapping onto slice pins
  // ---------------------------------------------------------------------
  logic [47:0] a_ext;
  logic [47:0] b_ext;
  logic [29:0] a_port;   // slice A input
  logic [17:0] b_port;   // slice B input
  logic [47:0] c_port;   // slice C input

  // Sign extension keeps bits above width consistent with the operand sign,
  // so the modulo-2^width result in P[width-1:0] is never disturbed.
  if (width >= 48) begin : g_no_ext
    assign a_ext = bus.a[47:0];
    assign b_ext = bus.b[47:0];
  end else begin : g_sign_ext
    assign a_ext = {{(48 - width){bus.a[width-1]}}, bus.a};
    assign b_ext = {{(48 - width){bus.b[width-1]}}, bus.b};
  end

  // a is split across the 30-bit A and 18-bit B pins so A:B re-forms it.
  assign a_port = a_ext[47:18];
  assign b_port = a_ext[17:0];
  assign c_port = b_ext;

  // Clock enables that are in use; A1/B1, M, AD, D and control CEs are tied
  // off because those registers are not part of this configuration.
  logic cea2;
  logic ceb2;
  logic cec;
  logic cep;

  assign cea2 = bus.en;
  assign ceb2 = bus.en;
  assign cec  = bus.en;
  assign cep  = bus.en;

  // ---------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------
  logic [29:0] a2_q, a2_d;
  logic [17:0] b2_q, b2_d;
  logic [47:0] c_q, c_d;
  logic [47:0] p_q, p_d;
  logic        v1_q, v1_d;
  logic        valid_out_q, valid_out_d;

  // Input register stage: A2, B2 and C capture together under en.
  always_comb begin
    a2_d = a2_q;
    b2_d = b2_q;
    c_d  = c_q;
    if (reset) begin
      a2_d = 30'd0;
      b2_d = 18'd0;
      c_d  = 48'd0;
    end else begin
      if (cea2) begin
        a2_d = a_port;
      end else begin
        a2_d = a2_q;
      end
      if (ceb2) begin
        b2_d = b_port;
      end else begin
        b2_d = b2_q;
      end
      if (cec) begin
        c_d = c_port;
      end else begin
        c_d = c_q;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Slice ALU input multiplexers
  // ---------------------------------------------------------------------
  logic [47:0] x_mux;
  logic [47:0] y_mux;
  logic [47:0] z_mux;
  logic [47:0] w_mux;
  logic        cin;

  // X/Y/Z/W selection from OPMODE; multiplier, PCIN and rounding sources do
  // not exist in this configuration and read as zero.
  always_comb begin
    x_mux = 48'd0;
    y_mux = 48'd0;
    z_mux = 48'd0;
    w_mux = 48'd0;

    case (OPMODE[1:0])
      2'b00:   x_mux = 48'd0;
      2'b01:   x_mux = 48'd0;            // M, multiplier unused
      2'b10:   x_mux = p_q;
      2'b11:   x_mux = {a2_q, b2_q};
      default: x_mux = 48'd0;
    endcase

    case (OPMODE[3:2])
      2'b00:   y_mux = 48'd0;
      2'b01:   y_mux = 48'd0;            // M, multiplier unused
      2'b10:   y_mux = 48'hFFFF_FFFF_FFFF;
      2'b11:   y_mux = c_q;
      default: y_mux = 48'd0;
    endcase

    case (OPMODE[6:4])
      3'b000:  z_mux = 48'd0;
      3'b001:  z_mux = 48'd0;            // PCIN, no cascade input
      3'b010:  z_mux = p_q;
      3'b011:  z_mux = c_q;
      3'b100:  z_mux = p_q;
      3'b101:  z_mux = 48'd0;            // PCIN >> 17, no cascade input
      3'b110:  z_mux = {{17{p_q[47]}}, p_q[47:17]};
      default: z_mux = 48'd0;
    endcase

    case (OPMODE[8:7])
      2'b00:   w_mux = 48'd0;
      2'b01:   w_mux = p_q;
      2'b10:   w_mux = 48'd0;            // RND, rounding constant is zero
      2'b11:   w_mux = c_q;
      default: w_mux = 48'd0;
    endcase
  end

  // Carry-in source selection.
  always_comb begin
    case (CARRYINSEL)
      3'b000:  cin = CARRYIN;
      default: cin = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Slice ALU
  // ---------------------------------------------------------------------
  logic [47:0] wxy_sum;
  logic [47:0] alu_out;

  // ALUMODE arithmetic; carries out of bit 47 are dropped, which is the
  // silent wrap the adder relies on.
  always_comb begin
    wxy_sum = w_mux + x_mux + y_mux + {47'd0, cin};
    case (ALUMODE)
      4'b0000: alu_out = z_mux + wxy_sum;
      4'b0001: alu_out = ~z_mux + wxy_sum;
      4'b0010: alu_out = ~(z_mux + wxy_sum);
      4'b0011: alu_out = z_mux - wxy_sum;
      default: alu_out = z_mux + wxy_sum;
    endcase
  end

  // P register and the fabric valid shift register advance together.
  always_comb begin
    p_d         = p_q;
    v1_d        = v1_q;
    valid_out_d = valid_out_q;
    if (reset) begin
      p_d         = 48'd0;
      v1_d        = 1'b0;
      valid_out_d = 1'b0;
    end else begin
      if (cep) begin
        p_d = alu_out;
      end else begin
        p_d = p_q;
      end
      if (bus.en) begin
        v1_d        = bus.valid_in;
        valid_out_d = v1_q;
      end else begin
        v1_d        = v1_q;
        valid_out_d = valid_out_q;
      end
    end
  end

  // State registers; reset and enable are already folded into the _d terms.
  always_ff @(posedge clock) begin
    a2_q        <= a2_d;
    b2_q        <= b2_d;
    c_q         <= c_d;
    p_q         <= p_d;
    v1_q        <= v1_d;
    valid_out_q <= valid_out_d;
  end

  assign bus.y         = p_q[width-1:0];
  assign bus.valid_out = valid_out_q;

endmodule

// File: tb/tb_dsp_add_reg.sv
// Self-checking bench for dsp_add_reg at several widths. Each instance has a
// queue-based reference model: every enabled edge pushes (valid_in, (a+b)
// mod 2^W) and the output is the entry pushed one enabled edge earlier, so a
// pair sampled at edge N shows after the next enabled edge. Directed
// literal checks pin the model on the cases called out for the block.
module tb_dsp_add_reg;

  localparam int NI = 8;
  localparam int WID [NI] = '{48, 8, 20, 1, 17, 18, 19, 47};

  typedef struct packed {
    logic        v;
    logic [47:0] s;
  } ent_t;

  logic clock = 1'b0;
  logic reset;
  logic en;
  logic rand_on;

  logic [47:0] dir_a [NI];
  logic [47:0] dir_b [NI];
  logic        dir_v [NI];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [47:0] act,
                     input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < NI; k++) begin
      dir_a[k] = 48'd0;
      dir_b[k] = 48'd0;
      dir_v[k] = 1'b0;
    end
  endtask

  task automatic put(input int k, input logic [47:0] a, input logic [47:0] b);
    dir_a[k] = a;
    dir_b[k] = b;
    dir_v[k] = 1'b1;
  endtask

  for (genvar k = 0; k < NI; k++) begin : g
    localparam int W = WID[k];

    dsp_add_reg_if #(.width(W)) bus ();
    dsp_add_reg #(.width(W)) dut (.clock(clock), .reset(reset), .bus(bus));

    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic         r_v;
    ent_t         q[$];
    logic         armed = 1'b0;

    assign bus.en       = en;
    assign bus.valid_in = rand_on ? r_v : dir_v[k];
    assign bus.a        = rand_on ? r_a : dir_a[k][W-1:0];
    assign bus.b        = rand_on ? r_b : dir_b[k][W-1:0];

    function automatic logic [W-1:0] pick();
      logic [63:0] t;
      int sel;
      sel = $urandom_range(0, 7);
      t = {$urandom(), $urandom()};
      if (sel == 0) t = '1;
      else if (sel == 1) t = 64'd1 << (W - 1);
      else if (sel == 2) t = 64'd0;
      return t[W-1:0];
    endfunction

    initial begin
      r_v = 1'b0;
      r_a = '0;
      r_b = '0;
      forever begin
        @(negedge clock);
        r_v = ($urandom_range(0, 3) != 0);
        r_a = pick();
        r_b = pick();
      end
    end

    // reference model update
    always @(posedge clock) begin
      ent_t e;
      logic [W-1:0] s;
      if (reset) begin
        q.delete();
        q.push_back('0);
        q.push_back('0);
        armed = 1'b1;
      end else if (en && armed) begin
        s = bus.a + bus.b;
        e = '0;
        e.v = bus.valid_in;
        e.s[W-1:0] = s;
        q.push_back(e);
        void'(q.pop_front());
      end
    end

    // per-cycle comparison against the model
    always @(posedge clock) begin
      #1;
      if (armed) begin
        n_cmp++;
        if (bus.valid_out !== q[0].v) begin
          n_bad++;
          $display("FAIL model_valid w%0d t=%0t: got %b expected %b",
                   W, $time, bus.valid_out, q[0].v);
        end
        if (q[0].v) begin
          n_cmp++;
          if (bus.y !== q[0].s[W-1:0]) begin
            n_bad++;
            $display("FAIL model_y w%0d t=%0t: got %h expected %h",
                     W, $time, bus.y, q[0].s[W-1:0]);
          end
        end
      end
    end
  end

  initial begin
    rand_on = 1'b0;
    en      = 1'b1;
    reset   = 1'b1;
    idle_all();

    // reset state
    @(negedge clock);
    chk("reset_y_w48", 48'(g[0].bus.y), 48'd0);
    chk("reset_v_w48", 48'(g[0].bus.valid_out), 48'd0);
    chk("reset_v_w8", 48'(g[1].bus.valid_out), 48'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // basic add (w48) and sign extension across the A:B split (w20)
    put(0, 48'h000000000005, 48'h000000000003);
    put(2, 48'h0000000FFFFF, 48'h000000000010);
    @(negedge clock);
    idle_all();
    @(negedge clock);
    chk("basic_v", 48'(g[0].bus.valid_out), 48'd1);
    chk("basic_y", 48'(g[0].bus.y), 48'h000000000008);
    chk("sext_v", 48'(g[2].bus.valid_out), 48'd1);
    chk("sext_y", 48'(g[2].bus.y), 48'h00000000000F);
    @(negedge clock);
    chk("basic_gap_v", 48'(g[0].bus.valid_out), 48'd0);
    repeat (2) @(negedge clock);

    // signed wrap at w8, back-to-back
    put(1, 48'h7F, 48'h01);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      if (i == 2) begin
        chk("wrap0_v", 48'(g[1].bus.valid_out), 48'd1);
        chk("wrap0_y", 48'(g[1].bus.y), 48'h80);
      end
      if (i == 3) begin
        chk("wrap1_v", 48'(g[1].bus.valid_out), 48'd1);
        chk("wrap1_y", 48'(g[1].bus.y), 48'h00);
      end
      if (i == 4) begin
        chk("wrap2_v", 48'(g[1].bus.valid_out), 48'd1);
        chk("wrap2_y", 48'(g[1].bus.y), 48'h00);
      end
      if (i == 1) put(1, 48'hFF, 48'h01);
      else if (i == 2) put(1, 48'h80, 48'h80);
      else idle_all();
    end
    @(negedge clock);
    chk("wrap_end_v", 48'(g[1].bus.valid_out), 48'd0);
    repeat (2) @(negedge clock);

    // stall: pair sampled, then en low for 5 edges
    put(0, 48'd10, 48'd20);
    @(negedge clock);
    idle_all();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_v", 48'(g[0].bus.valid_out), 48'd0);
      chk("stall_y", 48'(g[0].bus.y), 48'd0);
    end
    en = 1'b1;
    @(negedge clock);
    chk("resume_v", 48'(g[0].bus.valid_out), 48'd1);
    chk("resume_y", 48'(g[0].bus.y), 48'd30);
    @(negedge clock);
    chk("resume_gap_v", 48'(g[0].bus.valid_out), 48'd0);
    repeat (2) @(negedge clock);

    // reset mid-flight, with en low to show reset priority
    put(0, 48'd1, 48'd2);
    @(negedge clock);
    put(0, 48'd3, 48'd4);
    @(negedge clock);
    put(0, 48'd5, 48'd6);
    @(negedge clock);
    idle_all();
    reset = 1'b1;
    en    = 1'b0;
    @(negedge clock);
    chk("midrst_y", 48'(g[0].bus.y), 48'd0);
    chk("midrst_v", 48'(g[0].bus.valid_out), 48'd0);
    // release reset with a pair already presented
    reset = 1'b0;
    en    = 1'b1;
    put(0, 48'd7, 48'd8);
    @(negedge clock);
    idle_all();
    chk("postrst_v0", 48'(g[0].bus.valid_out), 48'd0);
    @(negedge clock);
    chk("postrst_v1", 48'(g[0].bus.valid_out), 48'd1);
    chk("postrst_y", 48'(g[0].bus.y), 48'd15);
    @(negedge clock);
    chk("postrst_v2", 48'(g[0].bus.valid_out), 48'd0);

    // random regression across all widths
    rand_on = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      en    = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 249) == 0);
    end
    @(negedge clock);
    reset   = 1'b0;
    rand_on = 1'b0;
    repeat (3) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
